// File: rtl/router_port_rx_if.sv
// Port-side bundle for router_port_rx: the active-low bit-serial stream from the
// crossbar plus the ready/valid byte interface toward the consumer.
// Handshake: a byte transfers on a rising edge where data_valid_o && data_ready_i;
// data_o/last_o are stable while data_valid_o is high and not yet accepted.
interface router_port_rx_if;
    logic       frame_i;
    logic       valid_i;
    logic       din;
    logic [7:0] data_o;
    logic       last_o;
    logic       data_valid_o;
    logic       data_ready_i;

    // Receiver view
    modport slave (
        input  frame_i,
        input  valid_i,
        input  din,
        input  data_ready_i,
        output data_o,
        output last_o,
        output data_valid_o
    );

    // Crossbar/consumer view (drives stream, accepts bytes)
    modport master (
        output frame_i,
        output valid_i,
        output din,
        output data_ready_i,
        input  data_o,
        input  last_o,
        input  data_valid_o
    );
endinterface

// File: rtl/router_port_rx.sv
// Receiving end of one router output port: deserializes the LSB-first serial
// stream into bytes, tags the packet's final byte and queues {byte,last} in a
// small FIFO drained by a ready/valid consumer.
module router_port_rx #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    router_port_rx_if.slave        bus,
    output logic                   busy_o,
    output logic                   err_o,
    output logic                   ovf_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [2:0]     bit_cnt_q;
    logic [7:0]     shift_q;
    logic           err_q, ovf_q;
    logic [8:0]     mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q;

    logic           capture, eop, byte_done, err_d;
    logic [7:0]     byte_val;
    logic           pop, push, drop;

    // Capture/end-of-packet decode and FSM next state
    always_comb begin
        state_d   = state_q;
        capture   = !bus.valid_i && ((state_q == RECV) || !bus.frame_i);
        eop       = (state_q == RECV) && bus.frame_i;
        byte_done = capture && (bit_cnt_q == 3'd7);
        byte_val  = {bus.din, shift_q[6:0]};
        // A packet ends cleanly only when its last capture completes a byte
        err_d     = eop && !byte_done;
        case (state_q)
            IDLE:    if (!bus.frame_i) state_d = RECV;
            RECV:    if (bus.frame_i)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FIFO push/pop decisions; a full FIFO still accepts a push when popping
    always_comb begin
        pop  = (count_q != '0) && bus.data_ready_i;
        push = byte_done && ((count_q != FULL) || pop);
        drop = byte_done && !push;
    end

    // FSM state, bit counter, shift register and status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            ovf_q   <= drop;
            if (eop) begin
                bit_cnt_q <= '0;
                shift_q   <= '0;
            end else if (capture) begin
                bit_cnt_q          <= bit_cnt_q + 3'd1;
                shift_q[bit_cnt_q] <= bus.din;
            end
        end
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {bus.frame_i, byte_val};
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

    assign bus.data_o       = mem_q[rd_ptr_q][7:0];
    assign bus.last_o       = mem_q[rd_ptr_q][8];
    assign bus.data_valid_o = (count_q != '0);
    assign busy_o           = (state_q == RECV);
    assign err_o            = err_q;
    assign ovf_o            = ovf_q;
    assign count_o          = count_q;
endmodule

// File: tb/tb_router_port_rx.sv
// Directed bench for router_port_rx: serial packets in, bytes checked against
// an expected queue of {last,byte} entries, status pulses checked per cycle.
module tb_router_port_rx;
    logic       clk;
    logic       rst;
    logic       busy_o, err_o, ovf_o;
    logic [2:0] count_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [8:0] exp_q[$];

    router_port_rx_if bus ();

    router_port_rx #(.DEPTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .busy_o  (busy_o),
        .err_o   (err_o),
        .ovf_o   (ovf_o),
        .count_o (count_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, time=%0t limit=200000", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // one clock with the given stream inputs; returns #1 after the edge
    task automatic cycle(input logic f, input logic v, input logic d);
        bus.frame_i = f;
        bus.valid_i = v;
        bus.din     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b1, 1'b1, 1'b0);
    endtask

    // Sends n bits LSB first; npad padding cycles before bit index pad_at;
    // finish=1 raises frame on the last bit; ready is 1 from bit ready_from on.
    task automatic send_bits(input logic [63:0] bits, input int n, input int pad_at,
                             input int npad, input bit finish, input int ready_from);
        for (int i = 0; i < n; i++) begin
            if (i == pad_at) begin
                for (int p = 0; p < npad; p++) begin
                    cycle(1'b0, 1'b1, 1'bx);
                    check("busy_pad", {31'd0, busy_o}, 32'd1);
                end
            end
            bus.data_ready_i = (i >= ready_from);
            cycle((finish && i == n - 1) ? 1'b1 : 1'b0, 1'b0, bits[i]);
            if (finish && i == n - 1) check("busy_end", {31'd0, busy_o}, 32'd0);
            else                      check("busy_bit", {31'd0, busy_o}, 32'd1);
        end
        bus.data_ready_i = 1'b0;
    endtask

    // pops every expected entry in order, then requires an empty FIFO
    task automatic drain();
        logic [8:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pop_valid", {31'd0, bus.data_valid_o}, 32'd1);
            check("pop_data",  {24'd0, bus.data_o}, {24'd0, e[7:0]});
            check("pop_last",  {31'd0, bus.last_o}, {31'd0, e[8]});
            bus.data_ready_i = 1'b1;
            idle();
            bus.data_ready_i = 1'b0;
        end
        check("drain_count", {29'd0, count_o}, 32'd0);
        check("drain_valid", {31'd0, bus.data_valid_o}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},  {24'd0, bus.data_o}, 32'd0);
        check({tag, "_last"},  {31'd0, bus.last_o}, 32'd0);
        check({tag, "_valid"}, {31'd0, bus.data_valid_o}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy_o}, 32'd0);
        check({tag, "_err"},   {31'd0, err_o}, 32'd0);
        check({tag, "_ovf"},   {31'd0, ovf_o}, 32'd0);
        check({tag, "_count"}, {29'd0, count_o}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.frame_i = 1'b1;
        bus.valid_i = 1'b1;
        bus.din = 1'b0;
        bus.data_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        idle();

        // 1: single byte 0xA5, frame high on the 8th bit
        send_bits(64'hA5, 8, 99, 0, 1'b1, 99);
        check("t1_valid", {31'd0, bus.data_valid_o}, 32'd1);
        check("t1_data",  {24'd0, bus.data_o}, 32'hA5);
        check("t1_last",  {31'd0, bus.last_o}, 32'd1);
        check("t1_err",   {31'd0, err_o}, 32'd0);
        exp_q.push_back({1'b1, 8'hA5});
        idle();
        drain();

        // 2: 0x3C,0x81 with 3 padding cycles between bits 5 and 6
        send_bits(64'h813C, 16, 6, 3, 1'b1, 99);
        check("t2_err",   {31'd0, err_o}, 32'd0);
        check("t2_count", {29'd0, count_o}, 32'd2);
        exp_q.push_back({1'b0, 8'h3C});
        exp_q.push_back({1'b1, 8'h81});
        idle();
        drain();

        // 3: 11-bit packet, then 0x12 proves bit_cnt restarted at 0
        send_bits(64'h5FF, 11, 99, 0, 1'b1, 99);
        check("t3_err",   {31'd0, err_o}, 32'd1);
        check("t3_count", {29'd0, count_o}, 32'd1);
        idle();
        check("t3_err_pulse", {31'd0, err_o}, 32'd0);
        send_bits(64'h12, 8, 99, 0, 1'b1, 99);
        check("t3b_err",  {31'd0, err_o}, 32'd0);
        exp_q.push_back({1'b0, 8'hFF});
        exp_q.push_back({1'b1, 8'h12});
        idle();
        drain();

        // 4a: 5 bytes with consumer stalled -> 5th dropped
        send_bits(64'h55_44_33_22_11, 40, 99, 0, 1'b1, 99);
        check("t4_ovf",   {31'd0, ovf_o}, 32'd1);
        check("t4_count", {29'd0, count_o}, 32'd4);
        check("t4_err",   {31'd0, err_o}, 32'd0);
        idle();
        check("t4_ovf_pulse", {31'd0, ovf_o}, 32'd0);
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h22});
        exp_q.push_back({1'b0, 8'h33});
        exp_q.push_back({1'b0, 8'h44});
        drain();

        // 4b: full FIFO, pop on the cycle the 5th byte completes -> no drop
        send_bits(64'h55_44_33_22_11, 40, 99, 0, 1'b1, 39);
        check("t4b_ovf",   {31'd0, ovf_o}, 32'd0);
        check("t4b_count", {29'd0, count_o}, 32'd4);
        exp_q.push_back({1'b0, 8'h22});
        exp_q.push_back({1'b0, 8'h33});
        exp_q.push_back({1'b0, 8'h44});
        exp_q.push_back({1'b1, 8'h55});
        idle();
        drain();

        // 5: reset mid-byte with 2 bytes queued
        send_bits(64'h7766, 16, 99, 0, 1'b1, 99);
        idle();
        check("t5_count_pre", {29'd0, count_o}, 32'd2);
        send_bits(64'hF, 4, 99, 0, 1'b0, 99);
        #2 rst = 1'b1;
        #1;
        check_all_zero("t5_async");
        bus.frame_i = 1'b1;
        bus.valid_i = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        send_bits(64'h5A, 8, 99, 0, 1'b1, 99);
        check("t5_count", {29'd0, count_o}, 32'd1);
        exp_q.push_back({1'b1, 8'h5A});
        idle();
        drain();

        // 6: back-to-back packets, frame falls right after end of packet
        send_bits(64'hC3, 8, 99, 0, 1'b1, 99);
        check("t6_err_a", {31'd0, err_o}, 32'd0);
        send_bits(64'h96, 8, 99, 0, 1'b1, 99);
        check("t6_err_b", {31'd0, err_o}, 32'd0);
        check("t6_count", {29'd0, count_o}, 32'd2);
        exp_q.push_back({1'b1, 8'hC3});
        exp_q.push_back({1'b1, 8'h96});
        idle();
        check("t6_err_c", {31'd0, err_o}, 32'd0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
